// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Package : tmr_pkg
// Brief   : Shared types and helpers for the TMR vote arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package tmr_pkg;

    // Controller states: wait for a request, sample the granted replicas,
    // present the voted result (and arbitrate for the next vote).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maj_voter.sv
`default_nettype none
// ============================================================================
// Module  : maj_voter
// Brief   : Bitwise 2-of-3 majority voter with per-replica disagreement flags.
// Revision: 1.0 - initial release
// ============================================================================
module maj_voter #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] w,
    output logic [2:0]   dis
);

    // Each output bit follows whichever value at least two replicas agree on.
    assign w   = (a & b) | (b & c) | (c & a);

    // A replica is flagged when any of its bits was outvoted; order is {c,b,a}.
    assign dis = {(c != w), (b != w), (a != w)};

endmodule
`default_nettype wire

// File: rtl/tmr_vote_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tmr_vote_arbiter
// Brief   : Round-robin sharing of one majority voter among N_CH triple-
//           redundant channels, with voted output, disagreement flags and a
//           saturating per-channel mismatch counter.
// Revision: 1.0 - initial release
// ============================================================================
module tmr_vote_arbiter
    import tmr_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*W-1:0]         a_data,
    input  logic [N_CH*W-1:0]         b_data,
    input  logic [N_CH*W-1:0]         c_data,
    output logic [N_CH-1:0]           gnt,
    output logic                      out_valid,
    output logic [W-1:0]              out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic [2:0]                out_dis,
    input  logic [$clog2(N_CH)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]          cnt_out,
    input  logic                      clr_cnt
);

    localparam int                c_idx_w    = idx_width(N_CH);
    localparam logic [c_idx_w:0]  c_n_ch_ext = (c_idx_w+1)'(N_CH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_CH - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [N_CH-1:0]   c_gnt_one  = N_CH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_gnt_idx;
    logic [N_CH-1:0]      r_gnt;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_data;
    logic [c_idx_w-1:0]   r_out_ch;
    logic [2:0]           r_out_dis;
    logic [CNT_W-1:0]     r_cnt [N_CH];

    // ------------------------------------------------------------------------
    // Round-robin arbiter: rotate requests so rr_ptr lands on bit 0, find the
    // lowest set bit, then rotate the offset back into a channel index.
    // ------------------------------------------------------------------------
    logic [N_CH-1:0]      w_req_rot;
    logic                 w_arb_hit;
    logic [c_idx_w-1:0]   w_arb_ofs;
    logic [c_idx_w:0]     w_arb_sum;
    logic [c_idx_w-1:0]   w_arb_idx;
    logic [c_idx_w-1:0]   w_next_rr;

    assign w_req_rot = N_CH'({req, req} >> r_rr_ptr);

    // Priority search over the rotated request vector (lowest offset wins).
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_ofs = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_arb_hit = 1'b1;
                w_arb_ofs = c_idx_w'(i);
            end
        end
    end

    assign w_arb_sum = {1'b0, r_rr_ptr} + {1'b0, w_arb_ofs};
    assign w_arb_idx = (w_arb_sum >= c_n_ch_ext) ? c_idx_w'(w_arb_sum - c_n_ch_ext)
                                                 : c_idx_w'(w_arb_sum);

    // After a completed capture the pointer moves just past the served channel.
    assign w_next_rr = (r_gnt_idx == c_last_idx) ? '0 : r_gnt_idx + c_idx_w'(1);

    // ------------------------------------------------------------------------
    // Vote path: the granted channel's replicas go straight through the voter
    // and the result is registered on the capture edge.
    // ------------------------------------------------------------------------
    logic [W-1:0] w_sel_a;
    logic [W-1:0] w_sel_b;
    logic [W-1:0] w_sel_c;
    logic [W-1:0] w_vote;
    logic [2:0]   w_dis;
    logic         w_capture;
    logic         w_cnt_inc;

    assign w_sel_a = a_data[r_gnt_idx*W +: W];
    assign w_sel_b = b_data[r_gnt_idx*W +: W];
    assign w_sel_c = c_data[r_gnt_idx*W +: W];

    maj_voter #(
        .W   (W)
    ) u_maj_voter (
        .a   (w_sel_a),
        .b   (w_sel_b),
        .c   (w_sel_c),
        .w   (w_vote),
        .dis (w_dis)
    );

    // A capture completes only if the requester is still asserting in its
    // grant cycle; otherwise the vote is dropped without side effects.
    assign w_capture = (r_state == CAPTURE) && req[r_gnt_idx];
    assign w_cnt_inc = w_capture && (|w_dis);

    // ------------------------------------------------------------------------
    // Sequencing FSM with registered grant and result outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_dis   <= '0;
        end else begin
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE, EMIT: begin
                    if (w_arb_hit) begin
                        r_gnt     <= c_gnt_one << w_arb_idx;
                        r_gnt_idx <= w_arb_idx;
                        r_state   <= CAPTURE;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (w_capture) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_vote;
                        r_out_ch    <= r_gnt_idx;
                        r_out_dis   <= w_dis;
                        r_rr_ptr    <= w_next_rr;
                        r_state     <= EMIT;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating mismatch counters; a clear overrides a same-cycle increment.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst || clr_cnt) begin
                r_cnt[i] <= '0;
            end else if (w_cnt_inc && (r_gnt_idx == c_idx_w'(i)) && (r_cnt[i] != c_cnt_max)) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_dis   = r_out_dis;
    assign cnt_out   = (int'(cnt_sel) < N_CH) ? r_cnt[cnt_sel] : '0;

endmodule
`default_nettype wire

// File: doc/tmr_vote_arbiter.md
# tmr_vote_arbiter

Shares a single bitwise majority voter among `N_CH` triple-redundant channels, each presenting three `W`-bit replicas (a, b, c).
- A round-robin arbiter grants one channel at a time and captures that channel's replicas.
- The block emits the voted word with a per-replica disagreement flag.
- It keeps a saturating mismatch counter per channel.
- It sits between the redundant producers and downstream logic, and is the sequencing controller for the majority-gate datapath.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels (≥2).
- `W`, 8: replica/word width.
- `CNT_W`, 8: mismatch counter width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_CH: per-channel vote request; held until granted.
- `a_data`, `b_data`, `c_data` in N_CH*W: replicas; channel k occupies bits [k*W +: W].
- `gnt` out N_CH: one-hot grant; the replicas are sampled in the cycle `gnt[k]`=1.
- `out_valid` out 1: one-cycle pulse; the voted result is present.
- `out_data` out W: bitwise majority of the captured replicas.
- `out_ch` out $clog2(N_CH): index of the channel the result belongs to.
- `out_dis` out 3: {c,b,a} disagreement flags; bit set if that replica ≠ `out_data`.
- `cnt_sel` in $clog2(N_CH): counter read select.
- `cnt_out` out CNT_W: mismatch counter of channel `cnt_sel`; combinational read of registered state.
- `clr_cnt` in 1: synchronous clear of all counters.

## Operation
FSM states:
- IDLE
  - If `|req`=0, stay.
  - Otherwise pick the first requesting channel at or after `rr_ptr` (wrapping), register `gnt` one-hot for it, and go to CAPTURE.
- CAPTURE
  - `gnt[k]`=1 for exactly this cycle.
  - If `req[k]`=1, latch `a_data`/`b_data`/`c_data` slice k into the vote path and go to EMIT. Also set `rr_ptr` = (k+1) mod N_CH.
  - If `req[k]`=0, the vote is aborted: no output, no counter update, `rr_ptr` unchanged, go to IDLE.
- EMIT
  - `out_valid`=1 with the registered `out_data`/`out_ch`/`out_dis`.
  - Arbitrates like IDLE in the same cycle: with a pending request, go to CAPTURE with a new `gnt`; otherwise go to IDLE.

Vote and counter rules:
- Vote: `out_data` = (a&b)|(b&c)|(c&a), bitwise.
- `out_dis[0]` = (a≠out_data); bits 1 and 2 are the same test for b and c.
- Mismatch event = `|out_dis`. On the CAPTURE→EMIT edge, `cnt[k]` increments by 1 and saturates at 2^CNT_W−1 (no wrap).
- `clr_cnt` clears all counters. It wins over a simultaneous increment.
- No backpressure on output: downstream must accept every `out_valid` pulse.
- A requester must hold `req` and stable data through its `gnt` cycle. It may deassert `req` the cycle after `gnt` or re-request immediately; it then competes behind others via `rr_ptr`.

## Timing
Reset (`rst`=1 at edge) leaves:
- `gnt`=0, `out_valid`=0, `out_data`=0, `out_ch`=0, `out_dis`=0.
- All counters 0, `rr_ptr`=0, state IDLE.
- `cnt_out` reads 0.

Reset mid-operation:
- Discards any granted or in-flight vote.
- No `out_valid` is produced for it.
- The counter is not updated.

Cycle timing:
- Latency: `req` seen in IDLE at cycle n → `gnt` at n+1 → `out_valid` at n+2.
- Sustained throughput with continuous requests: one result per 2 cycles (CAPTURE/EMIT alternate).
- `gnt` and `out_valid` never assert in the same cycle for the same vote. `gnt` for the next vote coincides with the previous EMIT cycle's successor (CAPTURE).
- Fairness: with all `req` high, grant order from reset is 0,1,2,…,N_CH−1,0.
- `cnt_out` reflects an increment or clear from the cycle after the edge that applied it.

## Structure
- Package `tmr_pkg`:
  - State enum {IDLE, CAPTURE, EMIT}.
  - A `clog2`-based index width helper.
- Sub-module `maj_voter` (combinational, parameter W):
  - Inputs a, b, c; outputs `w` (majority) and `dis[2:0]`.
  - Instantiated once in the vote path.
- Top holds:
  - Arbiter and `rr_ptr`.
  - FSM.
  - Capture registers.
  - Output registers.
  - Counter array.

## Test plan
- Reset then single request: `req`=0010, ch1 a=b=c=8'hA5 → `gnt`=0010 at cycle 1, `out_valid` at cycle 2 with `out_data`=A5, `out_ch`=1, `out_dis`=000, `cnt[1]`=0.
- Single-replica fault: ch2 a=8'h3C, b=8'h3C, c=8'hFF → `out_data`=3C, `out_dis`=100, `cnt[2]`=1.
- Bit-split vote: a=8'hF0, b=8'h0F, c=8'h33 → `out_data`=8'h33, `out_dis`=011.
- Round-robin fairness: all `req`=1111 held for 10 cycles → grant order 0,1,2,3,0, one `out_valid` every 2 cycles.
- Counter saturation/clear: CNT_W=2, four mismatching votes on ch0 → `cnt[0]` stays 3. Then `clr_cnt` coincident with a fifth mismatch → `cnt[0]`=0.
- Abort and reset:
  - `req[3]` dropped in its `gnt` cycle → no `out_valid`, `rr_ptr` unchanged.
  - `rst` asserted in CAPTURE → next cycle all outputs 0, no result emitted.
